// File: rtl/jt49_bus_master_pkg.sv
// Shared types for the jt49 bus master: FSM state encoding, command word layout
// and the phase-counter sizing helper.
package jt49_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    localparam int CMD_W = 13;

    typedef struct packed {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/jt49_bus_master_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x 13 bits. The head entry is always presented
// on rdata so the bus FSM can pop and load in the same cycle.
module jt49_cmd_fifo
    import jt49_bus_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  cmd_t wdata,
    output cmd_t rdata,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A push offered while full is refused even if a pop frees a slot this edge.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/jt49_bus_master.sv
// Bus initiator for the jt49 CPU port: queues write/read commands and plays them
// out as cs_n/wr_n cycles with fixed setup, strobe, hold and gap timing.
module jt49_bus_master
    import jt49_bus_master_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETUP  = 1,
    parameter int WR_LEN = 2,
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [3:0] psg_addr,
    output logic [7:0] psg_din,
    input  logic [7:0] psg_dout
);
    localparam int CW = $clog2(max_of4(SETUP, WR_LEN, RD_LAT, GAP) + 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP - 1);
    localparam logic [CW-1:0] LD_WR    = CW'(WR_LEN - 1);
    localparam logic [CW-1:0] LD_RD    = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'((GAP > 0) ? GAP - 1 : 0);

    cmd_t          cmd_in, head;
    logic          fifo_full, fifo_empty, pop;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;

    assign cmd_in = {cmd_rd, cmd_addr, cmd_data};

    jt49_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign psg_cs_n  = cs_n_q;
    assign psg_wr_n  = wr_n_q;
    assign psg_addr  = addr_q;
    assign psg_din   = din_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n_q;
        wr_n_d     = wr_n_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop    = 1'b1;
                addr_d = head.addr;
                cs_n_d = 1'b0;
                wr_n_d = 1'b1;
                if (head.rd) begin
                    state_d = ST_RDWAIT;
                    cnt_d   = LD_RD;
                end else begin
                    din_d   = head.data;
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            // wr_n can only fall from SETUP, so it never drops together with cs_n.
            ST_SETUP: if (cnt_q == '0) begin
                state_d = ST_STROBE;
                wr_n_d  = 1'b0;
                cnt_d   = LD_WR;
            end else cnt_d = cnt_q - CW'(1);
            ST_STROBE: if (cnt_q == '0) begin
                state_d = ST_HOLD;
                wr_n_d  = 1'b1;
            end else cnt_d = cnt_q - CW'(1);
            ST_HOLD: begin
                cs_n_d  = 1'b1;
                state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                cnt_d   = LD_GAP;
            end
            ST_RDWAIT: if (cnt_q == '0) begin
                rd_data_d  = psg_dout;
                rd_valid_d = 1'b1;
                cs_n_d     = 1'b1;
                state_d    = (GAP > 0) ? ST_GAP : ST_IDLE;
                cnt_d      = LD_GAP;
            end else cnt_d = cnt_q - CW'(1);
            ST_GAP: if (cnt_q == '0) state_d = ST_IDLE;
                    else cnt_d = cnt_q - CW'(1);
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_jt49_bus_master.sv
// Bench for jt49_bus_master: two instances (default timing and a stretched
// variant) each driving a small jt49 register-file model.
module tb_jt49_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- instance A (defaults) ----------------
    logic       cmd_valid_a = 1'b0, cmd_rd_a = 1'b0;
    logic [3:0] cmd_addr_a = '0;
    logic [7:0] cmd_data_a = '0;
    logic       cmd_ready_a, rd_valid_a, busy_a, cs_n_a, wr_n_a;
    logic [7:0] rd_data_a, din_a, dout_a;
    logic [3:0] addr_a;

    jt49_bus_master dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_rd(cmd_rd_a), .cmd_addr(cmd_addr_a), .cmd_data(cmd_data_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .busy(busy_a),
        .psg_cs_n(cs_n_a), .psg_wr_n(wr_n_a), .psg_addr(addr_a), .psg_din(din_a),
        .psg_dout(dout_a)
    );

    // ---------------- instance B (SETUP=3 WR_LEN=1 RD_LAT=1 GAP=0) ----------------
    logic       cmd_valid_b = 1'b0, cmd_rd_b = 1'b0;
    logic [3:0] cmd_addr_b = '0;
    logic [7:0] cmd_data_b = '0;
    logic       cmd_ready_b, rd_valid_b, busy_b, cs_n_b, wr_n_b;
    logic [7:0] rd_data_b, din_b, dout_b;
    logic [3:0] addr_b;

    jt49_bus_master #(.DEPTH(4), .SETUP(3), .WR_LEN(1), .RD_LAT(1), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_rd(cmd_rd_b), .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .busy(busy_b),
        .psg_cs_n(cs_n_b), .psg_wr_n(wr_n_b), .psg_addr(addr_b), .psg_din(din_b),
        .psg_dout(dout_b)
    );

    // jt49 register widths: unused upper bits read back as zero.
    function automatic logic [7:0] regmask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
            default:                 return 8'hFF;
        endcase
    endfunction

    // PSG models: write while cs_n&wr_n low, registered dout.
    logic [7:0] regs_a [16];
    logic [7:0] regs_b [16];
    always @(posedge clk) begin
        if (!cs_n_a && !wr_n_a) regs_a[addr_a] <= din_a & regmask(addr_a);
        dout_a <= regs_a[addr_a];
        if (!cs_n_b && !wr_n_b) regs_b[addr_b] <= din_b & regmask(addr_b);
        dout_b <= regs_b[addr_b];
    end

    // Monitor A: records bus events for the tasks to compare.
    logic [11:0] obs_wr[$];
    int          obs_wroff[$], obs_cslo[$], obs_wrlo[$], obs_cshi[$];
    logic [7:0]  obs_rd[$];
    int cs_lo = 0, wr_lo = 0, cs_hi = 0, egr = 0, bad_fall = 0, unstable = 0, rv_long = 0;
    logic cs_prev = 1'b1, wr_prev = 1'b1, rv_prev = 1'b0;
    logic [11:0] lat = '0;
    always @(posedge clk) begin
        cs_prev <= cs_n_a;
        wr_prev <= wr_n_a;
        rv_prev <= rd_valid_a;
        if (!cs_n_a) cs_lo <= cs_lo + 1;
        else if (cs_lo != 0) begin obs_cslo.push_back(cs_lo); cs_lo <= 0; end
        if (!wr_n_a) wr_lo <= wr_lo + 1;
        else if (wr_lo != 0) begin obs_wrlo.push_back(wr_lo); wr_lo <= 0; end
        if (cs_n_a) cs_hi <= cs_hi + 1;
        else if (cs_hi != 0) begin obs_cshi.push_back(cs_hi); cs_hi <= 0; end
        if (!cs_n_a && !wr_n_a && wr_prev) begin
            obs_wr.push_back({addr_a, din_a});
            obs_wroff.push_back(cs_lo);
            if (addr_a == 4'd13) egr <= egr + 1;
        end
        if (!cs_n_a && !wr_n_a && cs_prev) bad_fall <= bad_fall + 1;
        if (!cs_n_a && cs_prev) lat <= {addr_a, din_a};
        else if (!cs_n_a && ({addr_a, din_a} != lat)) unstable <= unstable + 1;
        if (rd_valid_a) obs_rd.push_back(rd_data_a);
        if (rd_valid_a && rv_prev) rv_long <= rv_long + 1;
    end

    // Monitor B
    int         obs_cslo_b[$], obs_wrlo_b[$];
    logic [7:0] obs_rd_b[$];
    int cs_lo_b = 0, wr_lo_b = 0;
    always @(posedge clk) begin
        if (!cs_n_b) cs_lo_b <= cs_lo_b + 1;
        else if (cs_lo_b != 0) begin obs_cslo_b.push_back(cs_lo_b); cs_lo_b <= 0; end
        if (!wr_n_b) wr_lo_b <= wr_lo_b + 1;
        else if (wr_lo_b != 0) begin obs_wrlo_b.push_back(wr_lo_b); wr_lo_b <= 0; end
        if (rd_valid_b) obs_rd_b.push_back(rd_data_b);
    end

    // Scoreboard queues of expected results
    logic [11:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          exp_cslo[$];

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction
    function automatic logic [11:0] qw(input logic [11:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 12'hxxx;
    endfunction
    function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic push_cmd(input bit b, input logic rd, input logic [3:0] a, input logic [7:0] d);
        int t = 0;
        if (b) begin cmd_valid_b = 1'b1; cmd_rd_b = rd; cmd_addr_b = a; cmd_data_b = d; end
        else   begin cmd_valid_a = 1'b1; cmd_rd_a = rd; cmd_addr_a = a; cmd_data_a = d; end
        while (!(b ? cmd_ready_b : cmd_ready_a) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) begin
            checks++; failures++;
            $display("FAIL push_timeout cmd_ready=0 after %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
    endtask

    task automatic drop_valid();
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit b);
        int t = 0;
        @(negedge clk);
        while ((b ? busy_b : busy_a) && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (t >= 300) begin failures++; $display("FAIL idle_timeout busy=1 required 0"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cs_n_a !== 1'b1)   begin failures++; $display("FAIL rst_cs_n got %b want 1", cs_n_a); end
        checks++; if (wr_n_a !== 1'b1)   begin failures++; $display("FAIL rst_wr_n got %b want 1", wr_n_a); end
        checks++; if (addr_a !== 4'h0)   begin failures++; $display("FAIL rst_addr got %h want 0", addr_a); end
        checks++; if (din_a !== 8'h00)   begin failures++; $display("FAIL rst_din got %h want 00", din_a); end
        checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got %b want 0", rd_valid_a); end
        checks++; if (rd_data_a !== 8'h00) begin failures++; $display("FAIL rst_rd_data got %h want 00", rd_data_a); end
        checks++; if (busy_a !== 1'b0)   begin failures++; $display("FAIL rst_busy got %b want 0", busy_a); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready_a !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_a); end
        checks++; if (cs_n_b !== 1'b1)   begin failures++; $display("FAIL rst_cs_n_b got %b want 1", cs_n_b); end
        @(negedge clk);
    endtask

    task automatic test_write();
        int i_wr = obs_wr.size(), i_lo = obs_cslo.size(), i_wl = obs_wrlo.size(), i_off = obs_wroff.size();
        int u0 = unstable;
        logic [11:0] e;
        int ei;
        exp_wr.push_back({4'd0, 8'h55});
        exp_cslo.push_back(4);
        push_cmd(0, 1'b0, 4'd0, 8'h55);
        drop_valid();
        wait_idle(0);
        e = exp_wr.pop_front();
        checks++; if (qw(obs_wr, i_wr) !== e) begin failures++; $display("FAIL wr_event got %h want %h", qw(obs_wr, i_wr), e); end
        ei = exp_cslo.pop_front();
        checks++; if (qi(obs_cslo, i_lo) != ei) begin failures++; $display("FAIL wr_cs_low got %0d want %0d", qi(obs_cslo, i_lo), ei); end
        checks++; if (qi(obs_wrlo, i_wl) != 2) begin failures++; $display("FAIL wr_strobe_len got %0d want 2", qi(obs_wrlo, i_wl)); end
        checks++; if (qi(obs_wroff, i_off) != 1) begin failures++; $display("FAIL wr_strobe_start got %0d want 1", qi(obs_wroff, i_off)); end
        checks++; if (unstable != u0) begin failures++; $display("FAIL wr_addr_din_stable got %0d changes want 0", unstable - u0); end
        checks++; if (regs_a[0] !== 8'h55) begin failures++; $display("FAIL wr_reg0 got %h want 55", regs_a[0]); end
    endtask

    task automatic test_eg_restart();
        int i_wr = obs_wr.size(), e0 = egr, f0 = bad_fall;
        logic [11:0] e;
        for (int k = 0; k < 2; k++) begin
            exp_wr.push_back({4'd13, 8'h0E});
            push_cmd(0, 1'b0, 4'd13, 8'h0E);
        end
        drop_valid();
        wait_idle(0);
        for (int k = 0; k < 2; k++) begin
            e = exp_wr.pop_front();
            checks++; if (qw(obs_wr, i_wr + k) !== e) begin failures++; $display("FAIL eg_wr%0d got %h want %h", k, qw(obs_wr, i_wr + k), e); end
        end
        checks++; if (egr - e0 != 2) begin failures++; $display("FAIL eg_restarts got %0d want 2", egr - e0); end
        checks++; if (bad_fall != f0) begin failures++; $display("FAIL eg_wr_fall_with_cs got %0d want 0", bad_fall - f0); end
        checks++; if (regs_a[13] !== 8'h0E) begin failures++; $display("FAIL eg_reg13 got %h want 0e", regs_a[13]); end
    endtask

    task automatic test_read();
        int i_rd = obs_rd.size(), i_lo = obs_cslo.size(), r0 = rv_long;
        logic [7:0] e;
        int ei;
        exp_cslo.push_back(4); exp_cslo.push_back(2); exp_cslo.push_back(4); exp_cslo.push_back(2);
        exp_rd.push_back(8'h0F); exp_rd.push_back(8'hA5);
        push_cmd(0, 1'b0, 4'd1, 8'hFF);
        push_cmd(0, 1'b1, 4'd1, 8'h00);
        push_cmd(0, 1'b0, 4'd0, 8'hA5);
        push_cmd(0, 1'b1, 4'd0, 8'h00);
        drop_valid();
        wait_idle(0);
        checks++; if (obs_rd.size() != i_rd + 2) begin failures++; $display("FAIL rd_pulses got %0d want 2", obs_rd.size() - i_rd); end
        for (int k = 0; k < 2; k++) begin
            e = exp_rd.pop_front();
            checks++; if (qb(obs_rd, i_rd + k) !== e) begin failures++; $display("FAIL rd_data%0d got %h want %h", k, qb(obs_rd, i_rd + k), e); end
        end
        for (int k = 0; k < 4; k++) begin
            ei = exp_cslo.pop_front();
            checks++; if (qi(obs_cslo, i_lo + k) != ei) begin failures++; $display("FAIL rd_cs_low%0d got %0d want %0d", k, qi(obs_cslo, i_lo + k), ei); end
        end
        checks++; if (rv_long != r0) begin failures++; $display("FAIL rd_valid_width got %0d long pulses want 0", rv_long - r0); end
    endtask

    task automatic test_back_to_back();
        int i_wr = obs_wr.size(), i_hi = obs_cshi.size();
        bit saw_full = 0;
        logic [3:0] a;
        logic [7:0] d;
        logic [11:0] e;
        for (int k = 0; k < 6; k++) begin
            a = 4'(2 * k + 2);
            d = 8'(8'h31 + 8'(k * 23));
            exp_wr.push_back({a, d});
            if (!cmd_ready_a) saw_full = 1;
            push_cmd(0, 1'b0, a, d);
        end
        drop_valid();
        wait_idle(0);
        checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL b2b_ready_low got %b want 1", saw_full); end
        for (int k = 0; k < 6; k++) begin
            e = exp_wr.pop_front();
            checks++; if (qw(obs_wr, i_wr + k) !== e) begin failures++; $display("FAIL b2b_order%0d got %h want %h", k, qw(obs_wr, i_wr + k), e); end
            checks++; if (regs_a[e[11:8]] !== (e[7:0] & regmask(e[11:8]))) begin
                failures++; $display("FAIL b2b_reg%0d got %h want %h", e[11:8], regs_a[e[11:8]], e[7:0] & regmask(e[11:8]));
            end
        end
        for (int k = 1; k < 6; k++) begin
            checks++; if (qi(obs_cshi, i_hi + k) != 2) begin failures++; $display("FAIL b2b_cs_high%0d got %0d want 2", k, qi(obs_cshi, i_hi + k)); end
        end
    endtask

    task automatic test_reset_mid();
        int i_wr = obs_wr.size();
        int t = 0;
        logic [11:0] e;
        push_cmd(0, 1'b0, 4'd2, 8'h33);
        drop_valid();
        @(negedge clk);
        while (wr_n_a && t < 50) begin @(negedge clk); t++; end
        checks++; if (wr_n_a !== 1'b0) begin failures++; $display("FAIL mid_strobe_seen wr_n=%b want 0", wr_n_a); end
        rst = 1'b1;
        #1;
        checks++; if (cs_n_a !== 1'b1)   begin failures++; $display("FAIL mid_rst_cs_n got %b want 1", cs_n_a); end
        checks++; if (wr_n_a !== 1'b1)   begin failures++; $display("FAIL mid_rst_wr_n got %b want 1", wr_n_a); end
        checks++; if (busy_a !== 1'b0)   begin failures++; $display("FAIL mid_rst_busy got %b want 0", busy_a); end
        checks++; if (cmd_ready_a !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b want 1", cmd_ready_a); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_wr.push_back({4'd2, 8'h44});
        push_cmd(0, 1'b0, 4'd2, 8'h44);
        drop_valid();
        wait_idle(0);
        e = exp_wr.pop_front();
        checks++; if (qw(obs_wr, i_wr) !== e) begin failures++; $display("FAIL mid_next_wr got %h want %h", qw(obs_wr, i_wr), e); end
        checks++; if (obs_cslo[$] != 4) begin failures++; $display("FAIL mid_next_cs_low got %0d want 4", obs_cslo[$]); end
        checks++; if (regs_a[2] !== 8'h44) begin failures++; $display("FAIL mid_reg2 got %h want 44", regs_a[2]); end
    endtask

    task automatic test_params();
        int i_lo = obs_cslo_b.size(), i_wl = obs_wrlo_b.size(), i_rd = obs_rd_b.size();
        int ei;
        logic [7:0] e;
        exp_cslo.push_back(5); exp_cslo.push_back(1);
        exp_rd.push_back(8'h0C);
        push_cmd(1, 1'b0, 4'd5, 8'h3C);
        push_cmd(1, 1'b1, 4'd5, 8'h00);
        drop_valid();
        wait_idle(1);
        for (int k = 0; k < 2; k++) begin
            ei = exp_cslo.pop_front();
            checks++; if (qi(obs_cslo_b, i_lo + k) != ei) begin failures++; $display("FAIL prm_cs_low%0d got %0d want %0d", k, qi(obs_cslo_b, i_lo + k), ei); end
        end
        checks++; if (qi(obs_wrlo_b, i_wl) != 1) begin failures++; $display("FAIL prm_strobe_len got %0d want 1", qi(obs_wrlo_b, i_wl)); end
        e = exp_rd.pop_front();
        checks++; if (qb(obs_rd_b, i_rd) !== e) begin failures++; $display("FAIL prm_rd_data got %h want %h", qb(obs_rd_b, i_rd), e); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_eg_restart();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
